// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: cache miss handler. It writes back a dirty victim when needed,
// fetches the requested line and presents it for a single-cycle array fill.
module line_fill_ctrl #(
  parameter int unsigned LINE_WIDTH    = 533,
  parameter int unsigned TAG_BITS      = 18,
  parameter int unsigned INDEX_BITS    = 8,
  parameter int unsigned OFFSET_BITS   = 6,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned WAYS          = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic [INDEX_BITS-1:0]    miss_index,
  input  logic [TAG_BITS-1:0]      miss_tag,
  input  logic [WAYS-1:0]          victim_way,
  input  logic [LINE_WIDTH-1:0]    victim_line,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  output logic                     mem_wvalid,
  input  logic                     mem_wready,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_rvalid,
  output logic                     mem_rready,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     fill_valid,
  output logic [INDEX_BITS-1:0]    fill_index,
  output logic [WAYS-1:0]          fill_way,
  output logic [LINE_WIDTH-1:0]    fill_line
);

  localparam int unsigned DATA_BITS = LINE_WIDTH - 3 - TAG_BITS;
  localparam int unsigned BEATS     = DATA_BITS / DATA_WIDTH;
  localparam int unsigned CNT_BITS  = $clog2(BEATS);
  localparam int unsigned LRU_BIT   = LINE_WIDTH - 1;
  localparam int unsigned VALID_BIT = LINE_WIDTH - 2;
  localparam int unsigned DIRTY_BIT = LINE_WIDTH - 3;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_DATA = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    FILL    = 3'd5
  } state_t;

  state_t                   state, state_next;
  logic [CNT_BITS-1:0]      cnt, cnt_next;
  logic [DATA_BITS-1:0]     wb_data;
  logic [TAG_BITS-1:0]      tag_q;
  logic                     accept, wbeat, rbeat;
  logic [ADDRESS_WIDTH-1:0] addr_next;
  logic                     unused_lru;

  // The victim's LRU bit has no role in miss handling.
  assign unused_lru = victim_line[LRU_BIT];

  // Write beats are shifted out of the low end of the captured victim data.
  assign mem_wdata = wb_data[DATA_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, beat counter and command address selection.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    wbeat      = 1'b0;
    rbeat      = 1'b0;
    addr_next  = mem_req_addr;
    case (state)
      IDLE: begin
        if (miss_valid) begin
          accept = 1'b1;
          if (victim_line[VALID_BIT] && victim_line[DIRTY_BIT]) begin
            state_next = WB_REQ;
            addr_next  = ADDRESS_WIDTH'({victim_line[DATA_BITS +: TAG_BITS], miss_index,
                                         OFFSET_BITS'(0)});
          end else begin
            state_next = RD_REQ;
            addr_next  = ADDRESS_WIDTH'({miss_tag, miss_index, OFFSET_BITS'(0)});
          end
        end
      end
      WB_REQ: begin
        if (mem_req_ready) begin
          state_next = WB_DATA;
          cnt_next   = '0;
        end
      end
      WB_DATA: begin
        if (mem_wready) begin
          wbeat    = 1'b1;
          cnt_next = cnt + CNT_BITS'(1);
          if (cnt == LAST_BEAT) begin
            state_next = RD_REQ;
            addr_next  = ADDRESS_WIDTH'({tag_q, fill_index, OFFSET_BITS'(0)});
          end
        end
      end
      RD_REQ: begin
        if (mem_req_ready) begin
          state_next = RD_DATA;
          cnt_next   = '0;
        end
      end
      RD_DATA: begin
        if (mem_rvalid) begin
          rbeat    = 1'b1;
          cnt_next = cnt + CNT_BITS'(1);
          if (cnt == LAST_BEAT) state_next = FILL;
        end
      end
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs decoded from the next state, plus miss capture and line assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_ready    <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_wvalid    <= 1'b0;
      mem_rready    <= 1'b0;
      fill_valid    <= 1'b0;
      fill_index    <= '0;
      fill_way      <= '0;
      fill_line     <= '0;
      wb_data       <= '0;
      tag_q         <= '0;
    end else begin
      miss_ready    <= (state_next == IDLE);
      mem_req_valid <= (state_next == WB_REQ) || (state_next == RD_REQ);
      mem_req_we    <= (state_next == WB_REQ);
      mem_wvalid    <= (state_next == WB_DATA);
      mem_rready    <= (state_next == RD_DATA);
      fill_valid    <= (state_next == FILL);
      mem_req_addr  <= addr_next;
      if (accept) begin
        fill_index <= miss_index;
        fill_way   <= victim_way;
        tag_q      <= miss_tag;
        wb_data    <= victim_line[DATA_BITS-1:0];
      end else if (wbeat) begin
        wb_data <= wb_data >> DATA_WIDTH;
      end
      if (rbeat) begin
        fill_line[DATA_BITS-1:0] <= {mem_rdata, fill_line[DATA_BITS-1:DATA_WIDTH]};
      end
      if (rbeat && (cnt == LAST_BEAT)) begin
        fill_line[LINE_WIDTH-1:DATA_BITS] <= {1'b1, 1'b1, 1'b0, tag_q};
      end
    end
  end

endmodule

// File: doc/line_fill_ctrl.md
# line_fill_ctrl

Miss-handling stage of the 4-way set-associative cache, directly downstream of victim-way selection. On a miss it accepts the set index, the requested tag, the selected victim way and that way's current line. If the victim is valid and dirty, it writes the line back to memory in 32-bit beats, then fetches the requested line in 32-bit beats. It then presents the assembled replacement line to the cache array for a single-cycle write.

## Interface
- LINE_WIDTH, 533, stored line width: [532] LRU, [531] valid, [530] dirty, [529:512] tag, [511:0] data
- TAG_BITS, 18, tag width
- INDEX_BITS, 8, set index width
- OFFSET_BITS, 6, byte offset width (64-byte line)
- DATA_WIDTH, 32, memory beat width; BEATS = 512/DATA_WIDTH = 16
- ADDRESS_WIDTH, 32, memory address width
- WAYS, 4, associativity
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss_valid  in  1  miss request present
- miss_ready  out  1  block idle; request accepted when miss_valid && miss_ready
- miss_index  in  INDEX_BITS  set of the miss
- miss_tag  in  TAG_BITS  tag of the requested line
- victim_way  in  WAYS  binary way number (0..WAYS-1) chosen for replacement
- victim_line  in  LINE_WIDTH  current contents of victim way
- mem_req_valid / mem_req_ready  out / in  1  memory command handshake
- mem_req_we  out  1  1 = writeback burst, 0 = line read burst
- mem_req_addr  out  ADDRESS_WIDTH  line-aligned address {tag, index, 6'b0}
- mem_wvalid / mem_wready  out / in  1  write-beat handshake
- mem_wdata  out  DATA_WIDTH  write beat
- mem_rvalid / mem_rready  in / out  1  read-beat handshake
- mem_rdata  in  DATA_WIDTH  read beat
- fill_valid  out  1  one-cycle strobe: write fill_line to [fill_index][fill_way]
- fill_index  out  INDEX_BITS  latched miss_index
- fill_way  out  WAYS  latched victim_way
- fill_line  out  LINE_WIDTH  {LRU=1, valid=1, dirty=0, miss_tag, fetched data}

## Operation
- States: IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL.
- IDLE: miss_ready=1. On acceptance, latch index, tag, way and victim_line. Go to WB_REQ if victim_line[531] && victim_line[530]; otherwise go to RD_REQ. The dirty bit without the valid bit never causes a writeback.
- WB_REQ: mem_req_valid=1, we=1, addr={victim tag [529:512], index, 6'b0}. Hold until mem_req_ready, then go to WB_DATA.
- WB_DATA: mem_wvalid=1, mem_wdata = data[32k+31:32k] for beat k. Beat 0 is sent first. k advances on wvalid && wready. After beat 15 is accepted, go to RD_REQ.
- RD_REQ: mem_req_valid=1, we=0, addr={miss_tag, index, 6'b0}. Hold until mem_req_ready, then go to RD_DATA.
- RD_DATA: mem_rready=1. Beat k is stored to fill data[32k+31:32k] on rvalid. After beat 15, go to FILL.
- FILL: fill_valid=1 for exactly one cycle, then go to IDLE.
- Beat counter is 4 bits. It clears on entry to WB_DATA and RD_DATA, and wraps 15→0 only on the exit beat.
- The command address and write data are held stable while their valid signal is high and ready is low.
- mem_rready=0 outside RD_DATA; rvalid arriving then is ignored. mem_wvalid=0 outside WB_DATA.
- Miss inputs are ignored while not in IDLE.
- victim_way is passed through unchecked.
- Clearing the LRU bits of sibling ways is the array writer's job, not this block's.

## Timing
- Reset (asynchronous, rst_n low): state=IDLE, counter=0, miss_ready=1. All other outputs are 0, including fill_line, fill_index and fill_way.
- Reset mid-burst: the transaction is aborted, no fill_valid is issued, and latched data is discarded.
- miss_ready is decoded from state (IDLE). After fill_valid it returns to 1 on the following cycle, so back-to-back misses are spaced by at least 1 idle cycle.
- Zero-wait memory, clean miss: accept at cycle 0, mem_req_valid at cycle 1, read beats at cycles 2–17, fill_valid at cycle 18.
- Dirty miss: writeback command at cycle 1, write beats at cycles 2–17, read command at cycle 18, read beats at cycles 19–34, fill_valid at cycle 35.
- Each ready/valid stall extends its state by exactly the stall cycles.
- fill_line, fill_index and fill_way are registered. They are valid during fill_valid and held until the next acceptance.

## Test plan
- Clean miss (victim valid=1, dirty=0), index 0x3A, tag 0x2ABCD, way 2, rdata beat k = 0x1000+k, zero-wait memory -> one read at addr {0x2ABCD,0x3A,6'b0}, no write beats, fill_valid at cycle 18, fill_line[31:0]=0x1000, fill_line[511:480]=0x100F, bits[532:530]=3'b110, fill_way=2.
- Dirty miss, victim tag 0x00011, data word k = 0xA0+k -> write command at addr {0x00011,index,6'b0}, 16 wdata beats 0xA0..0xAF in order, then read burst, fill_valid at cycle 35.
- Invalid-but-dirty victim (valid=0, dirty=1) -> no writeback, same timing as a clean miss.
- Random mem_req_ready, wready and rvalid stalls (0–3 cycles) -> address and wdata stable while stalled, no beat lost or duplicated, fill data matches the memory model.
- rst_n pulsed low at read beat 7 -> outputs go to reset values immediately, no fill_valid, miss_ready=1; the next miss completes normally.
- miss_valid held high across a fill -> second request accepted only in the IDLE cycle after fill_valid; inputs toggled mid-transaction are ignored.
